// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS core: registers EX results, runs the data-bus
// req/addr_ok/data_ok handshake, extends loads, places store lanes and feeds MEM/WB.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [3:0]  ex_memop_i,
  input  logic [31:0] ex_aluout_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic        ex_we_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_excepttype_i,
  input  logic        mem_flush_i,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  output logic [3:0]  data_wstrb_o,
  output logic        mem_stall_o,
  output logic        mem_we_o,
  output logic [4:0]  mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_load_o,
  output logic [31:0] mem_excepttype_o,
  output logic [31:0] mem_badvaddr_o,
  output logic [31:0] mem_pc_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_wdata_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd9;
  localparam logic [3:0] OP_SH  = 4'd10;
  localparam logic [3:0] OP_SW  = 4'd11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CANCEL} state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    return (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && a[0]) ||
           (((op == OP_LW) || (op == OP_SW)) && (a != 2'b00));
  endfunction

  state_e      state_q, state_d;
  logic        stall;
  logic        issue_ex;

  logic        s_valid_q;
  logic [3:0]  s_op_q;
  logic [31:0] s_addr_q;
  logic [31:0] s_wdata_q;
  logic [4:0]  s_waddr_q;
  logic        s_we_q;
  logic [31:0] s_pc_q;
  logic [31:0] s_except_q;

  logic        wb_we_q;
  logic [4:0]  wb_waddr_q;
  logic [31:0] wb_wdata_q;

  logic        s_misalign, s_is_load, s_is_store;
  logic [1:0]  a;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Issue is decided on the EX values being captured, so REQ starts the cycle after capture.
  assign issue_ex = ex_valid_i & ~mem_flush_i &
                    (is_load(ex_memop_i) | is_store(ex_memop_i)) &
                    ~misaligned(ex_memop_i, ex_aluout_i[1:0]) &
                    (ex_excepttype_i == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (issue_ex) state_d = REQ;
      REQ: begin
        if (mem_flush_i)         state_d = data_addr_ok_i ? CANCEL : IDLE;
        else if (data_addr_ok_i) state_d = WAIT;
      end
      // Completion edge also captures the next instruction, so chain straight into REQ.
      WAIT: begin
        if (data_data_ok_i)   state_d = issue_ex ? REQ : IDLE;
        else if (mem_flush_i) state_d = CANCEL;
      end
      CANCEL: if (data_data_ok_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_req_o = (state_q == REQ);
    stall      = (state_q == REQ) | (state_q == CANCEL) |
                 ((state_q == WAIT) & ~data_data_ok_i);
  end

  assign mem_stall_o = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid_q  <= 1'b0;
      s_op_q     <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_waddr_q  <= '0;
      s_we_q     <= 1'b0;
      s_pc_q     <= '0;
      s_except_q <= '0;
    end else if (!stall) begin
      s_valid_q  <= ex_valid_i & ~mem_flush_i;
      s_op_q     <= ex_memop_i;
      s_addr_q   <= ex_aluout_i;
      s_wdata_q  <= ex_wdata_i;
      s_waddr_q  <= ex_waddr_i;
      s_we_q     <= ex_we_i;
      s_pc_q     <= ex_pc_i;
      s_except_q <= ex_excepttype_i;
    end else if (mem_flush_i) begin
      s_valid_q  <= 1'b0;
    end
  end

  assign a          = s_addr_q[1:0];
  assign s_is_load  = is_load(s_op_q);
  assign s_is_store = is_store(s_op_q);
  assign s_misalign = misaligned(s_op_q, a);

  always_comb begin
    case (a)
      2'd0:    ld_byte = data_rdata_i[7:0];
      2'd1:    ld_byte = data_rdata_i[15:8];
      2'd2:    ld_byte = data_rdata_i[23:16];
      default: ld_byte = data_rdata_i[31:24];
    endcase
    ld_half = a[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (s_op_q)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'd0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'd0, ld_half};
      default: ld_ext = data_rdata_i;
    endcase
  end

  always_comb begin
    data_wdata_o = '0;
    data_wstrb_o = '0;
    data_size_o  = 2'd0;
    case (s_op_q)
      OP_SB: begin
        data_wdata_o = {4{s_wdata_q[7:0]}};
        data_wstrb_o = 4'b0001 << a;
        data_size_o  = 2'd0;
      end
      OP_SH: begin
        data_wdata_o = {2{s_wdata_q[15:0]}};
        data_wstrb_o = a[1] ? 4'b1100 : 4'b0011;
        data_size_o  = 2'd1;
      end
      OP_SW: begin
        data_wdata_o = s_wdata_q;
        data_wstrb_o = 4'b1111;
        data_size_o  = 2'd2;
      end
      OP_LH, OP_LHU: data_size_o = 2'd1;
      OP_LW:         data_size_o = 2'd2;
      default:       data_size_o = 2'd0;
    endcase
  end

  assign data_addr_o = s_addr_q;
  assign data_wr_o   = s_op_q[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_q    <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
    end else if (!stall) begin
      wb_we_q    <= s_valid_q & s_we_q & ~mem_flush_i & (s_except_q == '0) &
                    ~s_misalign & ~s_is_store;
      wb_waddr_q <= s_waddr_q;
      wb_wdata_q <= s_is_load ? ld_ext : s_addr_q;
    end
  end

  assign wb_we_o    = wb_we_q;
  assign wb_waddr_o = wb_waddr_q;
  assign wb_wdata_o = wb_wdata_q;

  assign mem_we_o         = s_valid_q & s_we_q;
  assign mem_waddr_o      = s_waddr_q;
  assign mem_wdata_o      = s_addr_q;
  assign mem_load_o       = s_valid_q & s_is_load;
  assign mem_excepttype_o = s_valid_q ?
    (s_except_q | {26'd0, s_misalign & s_is_store, s_misalign & s_is_load, 4'd0}) : '0;
  assign mem_badvaddr_o   = s_addr_q;
  assign mem_pc_o         = s_pc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: handshake timing, load extension, store lanes,
// alignment exceptions, flush draining and asynchronous reset.
module tb_mem_stage;

  logic        clk, rst;
  logic        ex_valid_i;
  logic [3:0]  ex_memop_i;
  logic [31:0] ex_aluout_i, ex_wdata_i, ex_pc_i, ex_excepttype_i;
  logic [4:0]  ex_waddr_i;
  logic        ex_we_i;
  logic        mem_flush_i, data_addr_ok_i, data_data_ok_i;
  logic [31:0] data_rdata_i;
  logic        data_req_o, data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_wstrb_o;
  logic        mem_stall_o, mem_we_o, mem_load_o;
  logic [4:0]  mem_waddr_o;
  logic [31:0] mem_wdata_o, mem_excepttype_o, mem_badvaddr_o, mem_pc_o;
  logic        wb_we_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;

  int passed = 0;
  int total  = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_memop_i(ex_memop_i), .ex_aluout_i(ex_aluout_i),
    .ex_wdata_i(ex_wdata_i), .ex_waddr_i(ex_waddr_i), .ex_we_i(ex_we_i),
    .ex_pc_i(ex_pc_i), .ex_excepttype_i(ex_excepttype_i),
    .mem_flush_i(mem_flush_i), .data_addr_ok_i(data_addr_ok_i),
    .data_data_ok_i(data_data_ok_i), .data_rdata_i(data_rdata_i),
    .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_wstrb_o(data_wstrb_o),
    .mem_stall_o(mem_stall_o), .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o), .mem_load_o(mem_load_o),
    .mem_excepttype_o(mem_excepttype_o), .mem_badvaddr_o(mem_badvaddr_o),
    .mem_pc_o(mem_pc_o), .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o),
    .wb_wdata_o(wb_wdata_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] wa, input logic we);
    ex_valid_i      = 1'b1;
    ex_memop_i      = op;
    ex_aluout_i     = addr;
    ex_wdata_i      = wd;
    ex_waddr_i      = wa;
    ex_we_i         = we;
    ex_pc_i         = 32'hBFC0_0100;
    ex_excepttype_i = 32'd0;
  endtask

  task automatic clear_ex;
    ex_valid_i = 1'b0;
    ex_memop_i = 4'd0;
    ex_we_i    = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({data_req_o, data_wr_o, mem_stall_o, mem_we_o, mem_load_o, wb_we_o} !== 6'b0) $display("FAIL reset_ctrl: got %b expected 000000", {data_req_o, data_wr_o, mem_stall_o, mem_we_o, mem_load_o, wb_we_o});
    else passed++;
    total++;
    if ({data_addr_o, data_wdata_o, wb_wdata_o, mem_excepttype_o, mem_pc_o} !== 160'd0) $display("FAIL reset_data: got nonzero data outputs, expected all zero");
    else passed++;
    total++;
    if ({data_wstrb_o, data_size_o, wb_waddr_o, mem_waddr_o} !== 16'd0) $display("FAIL reset_fields: got %h expected 0", {data_wstrb_o, data_size_o, wb_waddr_o, mem_waddr_o});
    else passed++;
    step;
    rst = 1'b0;
  endtask

  task automatic test_alu_op;
    drive_ex(4'd0, 32'h0000_1234, 32'd0, 5'd7, 1'b1);
    step;
    clear_ex;
    #1;
    total++;
    if ({mem_we_o, mem_load_o, mem_stall_o, data_req_o} !== 4'b1000) $display("FAIL alu_mem_flags: got %b expected 1000", {mem_we_o, mem_load_o, mem_stall_o, data_req_o});
    else passed++;
    total++;
    if (mem_wdata_o !== 32'h0000_1234 || mem_pc_o !== 32'hBFC0_0100) $display("FAIL alu_mem_fwd: got %h/%h expected 00001234/bfc00100", mem_wdata_o, mem_pc_o);
    else passed++;
    step;
    total++;
    if (wb_we_o !== 1'b1 || wb_wdata_o !== 32'h0000_1234 || wb_waddr_o !== 5'd7) $display("FAIL alu_wb: got we=%b d=%h a=%0d expected 1/00001234/7", wb_we_o, wb_wdata_o, wb_waddr_o);
    else passed++;
  endtask

  task automatic test_lw_aligned;
    int stall_cnt;
    stall_cnt = 0;
    drive_ex(4'd5, 32'h8000_0004, 32'd0, 5'd5, 1'b1);
    step;
    clear_ex;
    #1;
    total++;
    if (data_req_o !== 1'b1 || data_addr_o !== 32'h8000_0004 || data_wr_o !== 1'b0 || data_size_o !== 2'd2 || data_wstrb_o !== 4'd0) $display("FAIL lw_req: got req=%b addr=%h wr=%b size=%0d strb=%b expected 1/80000004/0/2/0000", data_req_o, data_addr_o, data_wr_o, data_size_o, data_wstrb_o);
    else passed++;
    total++;
    if (mem_load_o !== 1'b1) $display("FAIL lw_mem_load: got %b expected 1", mem_load_o);
    else passed++;
    stall_cnt += int'(mem_stall_o);
    step; #1;
    stall_cnt += int'(mem_stall_o);
    step;
    data_addr_ok_i = 1'b1;
    #1;
    stall_cnt += int'(mem_stall_o);
    step;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'hDEAD_BEEF;
    #1;
    stall_cnt += int'(mem_stall_o);
    step;
    data_data_ok_i = 1'b0;
    #1;
    stall_cnt += int'(mem_stall_o);
    total++;
    if (wb_we_o !== 1'b1 || wb_wdata_o !== 32'hDEAD_BEEF || wb_waddr_o !== 5'd5) $display("FAIL lw_wb: got we=%b d=%h a=%0d expected 1/deadbeef/5", wb_we_o, wb_wdata_o, wb_waddr_o);
    else passed++;
    total++;
    if (stall_cnt !== 3) $display("FAIL lw_stall_cycles: got %0d expected 3", stall_cnt);
    else passed++;
  endtask

  logic [3:0]  lx_op   [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
  logic [31:0] lx_addr [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
  logic [31:0] lx_exp  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012, 32'h0000_3456};

  task automatic test_load_ext;
    for (int i = 0; i < 4; i++) begin
      drive_ex(lx_op[i], lx_addr[i], 32'd0, 5'd9, 1'b1);
      step;
      clear_ex;
      data_addr_ok_i = 1'b1;
      #1;
      step;
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b1;
      data_rdata_i   = 32'h8012_3456;
      #1;
      step;
      data_data_ok_i = 1'b0;
      total++;
      if (wb_we_o !== 1'b1 || wb_wdata_o !== lx_exp[i]) $display("FAIL load_ext_%0d: got we=%b d=%h expected 1/%h", i, wb_we_o, wb_wdata_o, lx_exp[i]);
      else passed++;
    end
  endtask

  task automatic test_sb_lanes;
    drive_ex(4'd9, 32'h0000_0001, 32'h0000_00AB, 5'd0, 1'b0);
    step;
    clear_ex;
    data_addr_ok_i = 1'b1;
    #1;
    total++;
    if (data_req_o !== 1'b1 || data_wdata_o !== 32'hABAB_ABAB) $display("FAIL sb_wdata: got req=%b d=%h expected 1/abababab", data_req_o, data_wdata_o);
    else passed++;
    total++;
    if (data_wstrb_o !== 4'b0010 || data_size_o !== 2'd0 || data_wr_o !== 1'b1) $display("FAIL sb_ctrl: got strb=%b size=%0d wr=%b expected 0010/0/1", data_wstrb_o, data_size_o, data_wr_o);
    else passed++;
    step;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    #1;
    step;
    data_data_ok_i = 1'b0;
    total++;
    if (wb_we_o !== 1'b0) $display("FAIL sb_wb_we: got %b expected 0", wb_we_o);
    else passed++;
  endtask

  task automatic test_misalign;
    drive_ex(4'd5, 32'h0000_0002, 32'd0, 5'd3, 1'b1);
    step;
    clear_ex;
    #1;
    total++;
    if (data_req_o !== 1'b0 || mem_stall_o !== 1'b0) $display("FAIL lw_mis_req: got req=%b stall=%b expected 0/0", data_req_o, mem_stall_o);
    else passed++;
    total++;
    if (mem_excepttype_o !== 32'h0000_0010 || mem_badvaddr_o !== 32'h0000_0002) $display("FAIL lw_mis_exc: got exc=%h bad=%h expected 00000010/00000002", mem_excepttype_o, mem_badvaddr_o);
    else passed++;
    step;
    total++;
    if (wb_we_o !== 1'b0 || data_req_o !== 1'b0) $display("FAIL lw_mis_wb: got we=%b req=%b expected 0/0", wb_we_o, data_req_o);
    else passed++;
    drive_ex(4'd10, 32'h0000_0003, 32'h0000_1234, 5'd0, 1'b0);
    step;
    clear_ex;
    #1;
    total++;
    if (mem_excepttype_o !== 32'h0000_0020 || data_req_o !== 1'b0) $display("FAIL sh_mis_exc: got exc=%h req=%b expected 00000020/0", mem_excepttype_o, data_req_o);
    else passed++;
    step;
  endtask

  task automatic test_flush_wait;
    drive_ex(4'd5, 32'h0000_0010, 32'd0, 5'd4, 1'b1);
    step;
    clear_ex;
    data_addr_ok_i = 1'b1;
    step;
    data_addr_ok_i = 1'b0;
    mem_flush_i    = 1'b1;
    #1;
    total++;
    if (mem_stall_o !== 1'b1) $display("FAIL fw_wait_stall: got %b expected 1", mem_stall_o);
    else passed++;
    step;
    mem_flush_i = 1'b0;
    drive_ex(4'd5, 32'h0000_0020, 32'd0, 5'd6, 1'b1);
    #1;
    total++;
    if (mem_stall_o !== 1'b1 || data_req_o !== 1'b0) $display("FAIL fw_cancel: got stall=%b req=%b expected 1/0", mem_stall_o, data_req_o);
    else passed++;
    step;
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h1234_5678;
    #1;
    total++;
    if (mem_stall_o !== 1'b1) $display("FAIL fw_cancel_dok_stall: got %b expected 1", mem_stall_o);
    else passed++;
    step;
    data_data_ok_i = 1'b0;
    #1;
    total++;
    if (data_req_o !== 1'b0 || mem_stall_o !== 1'b0) $display("FAIL fw_idle: got req=%b stall=%b expected 0/0", data_req_o, mem_stall_o);
    else passed++;
    step;
    clear_ex;
    #1;
    total++;
    if (wb_we_o !== 1'b0) $display("FAIL fw_no_wb: got %b expected 0", wb_we_o);
    else passed++;
    total++;
    if (data_req_o !== 1'b1 || data_addr_o !== 32'h0000_0020) $display("FAIL fw_next_req: got req=%b addr=%h expected 1/00000020", data_req_o, data_addr_o);
    else passed++;
    data_addr_ok_i = 1'b1;
    step;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'hCAFE_0001;
    #1;
    step;
    data_data_ok_i = 1'b0;
    total++;
    if (wb_we_o !== 1'b1 || wb_wdata_o !== 32'hCAFE_0001 || wb_waddr_o !== 5'd6) $display("FAIL fw_next_wb: got we=%b d=%h a=%0d expected 1/cafe0001/6", wb_we_o, wb_wdata_o, wb_waddr_o);
    else passed++;
  endtask

  task automatic test_flush_req;
    drive_ex(4'd5, 32'h0000_0030, 32'd0, 5'd2, 1'b1);
    step;
    clear_ex;
    mem_flush_i = 1'b1;
    #1;
    total++;
    if (data_req_o !== 1'b1) $display("FAIL fr_req_before: got %b expected 1", data_req_o);
    else passed++;
    step;
    mem_flush_i = 1'b0;
    #1;
    total++;
    if (data_req_o !== 1'b0 || mem_stall_o !== 1'b0 || mem_load_o !== 1'b0) $display("FAIL fr_dropped: got req=%b stall=%b load=%b expected 0/0/0", data_req_o, mem_stall_o, mem_load_o);
    else passed++;
    step;
  endtask

  task automatic test_back_to_back;
    drive_ex(4'd5, 32'h0000_0050, 32'd0, 5'd10, 1'b1);
    step;
    drive_ex(4'd5, 32'h0000_0054, 32'd0, 5'd11, 1'b1);
    data_addr_ok_i = 1'b1;
    step;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h1111_1111;
    #1;
    total++;
    if (mem_stall_o !== 1'b0) $display("FAIL b2b_release: got stall=%b expected 0", mem_stall_o);
    else passed++;
    step;
    clear_ex;
    data_data_ok_i = 1'b0;
    #1;
    total++;
    if (wb_we_o !== 1'b1 || wb_wdata_o !== 32'h1111_1111 || wb_waddr_o !== 5'd10) $display("FAIL b2b_first_wb: got we=%b d=%h a=%0d expected 1/11111111/10", wb_we_o, wb_wdata_o, wb_waddr_o);
    else passed++;
    total++;
    if (data_req_o !== 1'b1 || data_addr_o !== 32'h0000_0054) $display("FAIL b2b_second_req: got req=%b addr=%h expected 1/00000054", data_req_o, data_addr_o);
    else passed++;
    data_addr_ok_i = 1'b1;
    step;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h2222_2222;
    #1;
    step;
    data_data_ok_i = 1'b0;
    total++;
    if (wb_we_o !== 1'b1 || wb_wdata_o !== 32'h2222_2222 || wb_waddr_o !== 5'd11) $display("FAIL b2b_second_wb: got we=%b d=%h a=%0d expected 1/22222222/11", wb_we_o, wb_wdata_o, wb_waddr_o);
    else passed++;
  endtask

  task automatic test_reset_mid_wait;
    drive_ex(4'd0, 32'h0000_A5A5, 32'd0, 5'd12, 1'b1);
    step;
    drive_ex(4'd5, 32'h0000_0040, 32'd0, 5'd13, 1'b1);
    step;
    clear_ex;
    data_addr_ok_i = 1'b1;
    step;
    data_addr_ok_i = 1'b0;
    #1;
    total++;
    if (mem_stall_o !== 1'b1 || wb_we_o !== 1'b1 || wb_wdata_o !== 32'h0000_A5A5) $display("FAIL rmw_pre: got stall=%b we=%b d=%h expected 1/1/0000a5a5", mem_stall_o, wb_we_o, wb_wdata_o);
    else passed++;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({data_req_o, data_wr_o, mem_stall_o, mem_we_o, mem_load_o, wb_we_o} !== 6'b0) $display("FAIL rmw_ctrl: got %b expected 000000", {data_req_o, data_wr_o, mem_stall_o, mem_we_o, mem_load_o, wb_we_o});
    else passed++;
    total++;
    if (data_addr_o !== 32'd0 || wb_wdata_o !== 32'd0 || mem_wdata_o !== 32'd0 || data_size_o !== 2'd0) $display("FAIL rmw_data: got addr=%h wb=%h mw=%h size=%0d expected all 0", data_addr_o, wb_wdata_o, mem_wdata_o, data_size_o);
    else passed++;
    step;
    rst = 1'b0;
    step;
  endtask

  initial begin
    rst             = 1'b1;
    ex_valid_i      = 1'b0;
    ex_memop_i      = 4'd0;
    ex_aluout_i     = 32'd0;
    ex_wdata_i      = 32'd0;
    ex_waddr_i      = 5'd0;
    ex_we_i         = 1'b0;
    ex_pc_i         = 32'd0;
    ex_excepttype_i = 32'd0;
    mem_flush_i     = 1'b0;
    data_addr_ok_i  = 1'b0;
    data_data_ok_i  = 1'b0;
    data_rdata_i    = 32'd0;

    test_reset;
    test_alu_op;
    test_lw_aligned;
    test_load_ext;
    test_sb_lanes;
    test_misalign;
    test_flush_wait;
    test_flush_req;
    test_back_to_back;
    test_reset_mid_wait;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
